// File: rtl/dual_issue_split_issuer_if.sv
// Fetch/issue bundle for the split issuer: fetch pair in, head pair out to
// the hazard checker, split request back, and the issue beat out.
interface dual_issue_split_issuer_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_instr1;
  logic [XLEN-1:0] in_instr2;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] head_instr1;
  logic [XLEN-1:0] head_instr2;
  logic            split_req;
  logic            out_valid;
  logic            issue_ready;
  logic [XLEN-1:0] out_instr1;
  logic [XLEN-1:0] out_instr2;
  logic [XLEN-1:0] out_pc1;
  logic [XLEN-1:0] out_pc2;
  logic            out_nop1;
  logic            out_nop2;

  modport slave (
    input  in_valid, in_instr1, in_instr2, in_pc, split_req, issue_ready,
    output in_ready, head_instr1, head_instr2, out_valid,
           out_instr1, out_instr2, out_pc1, out_pc2, out_nop1, out_nop2
  );

  modport master (
    output in_valid, in_instr1, in_instr2, in_pc, split_req, issue_ready,
    input  in_ready, head_instr1, head_instr2, out_valid,
           out_instr1, out_instr2, out_pc1, out_pc2, out_nop1, out_nop2
  );
endinterface

// File: rtl/dual_issue_split_issuer.sv
// Buffers fetched instruction pairs and issues each as one dual beat, or as two
// single-slot beats (slot2 bubbled first, then slot1) when the hazard checker splits it.
module dual_issue_split_issuer #(
  parameter int              XLEN      = 32,
  parameter int              DEPTH     = 2,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  dual_issue_split_issuer_if.slave bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic {PAIR, SPLIT2} state_t;

  logic [XLEN-1:0] fifo_instr1 [DEPTH];
  logic [XLEN-1:0] fifo_instr2 [DEPTH];
  logic [XLEN-1:0] fifo_pc     [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;

  state_t          state;
  state_t          state_next;

  logic            head_valid;
  logic            full;
  logic            push;
  logic            pop;
  logic            load;
  logic [XLEN-1:0] beat_instr1;
  logic [XLEN-1:0] beat_instr2;
  logic [XLEN-1:0] beat_pc1;
  logic [XLEN-1:0] beat_pc2;
  logic            beat_nop1;
  logic            beat_nop2;

  assign head_valid      = (count != '0);
  assign full            = (count == CW'(DEPTH));
  assign bus.in_ready    = !rst && !full;
  assign push            = bus.in_valid && bus.in_ready && !flush;
  assign load            = head_valid && (!bus.out_valid || bus.issue_ready) && !flush && !rst;
  assign bus.head_instr1 = head_valid ? fifo_instr1[rd_ptr] : NOP_INSTR;
  assign bus.head_instr2 = head_valid ? fifo_instr2[rd_ptr] : NOP_INSTR;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state <= PAIR;
    end else begin
      state <= state_next;
    end
  end

  // split_req only matters on the first beat of a pair; SPLIT2 always completes it
  always_comb begin
    state_next = state;
    if (load) begin
      case (state)
        PAIR:    if (bus.split_req) state_next = SPLIT2;
        SPLIT2:  state_next = PAIR;
        default: state_next = PAIR;
      endcase
    end
  end

  always_comb begin
    beat_instr1 = fifo_instr1[rd_ptr];
    beat_instr2 = fifo_instr2[rd_ptr];
    beat_pc1    = fifo_pc[rd_ptr];
    beat_pc2    = fifo_pc[rd_ptr] + XLEN'(4);
    beat_nop1   = 1'b0;
    beat_nop2   = 1'b0;
    pop         = 1'b0;
    case (state)
      PAIR: begin
        if (bus.split_req) begin
          beat_instr2 = NOP_INSTR;
          beat_nop2   = 1'b1;
        end else begin
          pop = load;
        end
      end
      SPLIT2: begin
        beat_instr1 = NOP_INSTR;
        beat_nop1   = 1'b1;
        pop         = load;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr1[wr_ptr] <= bus.in_instr1;
      fifo_instr2[wr_ptr] <= bus.in_instr2;
      fifo_pc[wr_ptr]     <= bus.in_pc;
    end
  end

  // DEPTH is a power of two, so plain pointer increment wraps modulo DEPTH
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      bus.out_valid  <= 1'b0;
      bus.out_instr1 <= NOP_INSTR;
      bus.out_instr2 <= NOP_INSTR;
      bus.out_pc1    <= '0;
      bus.out_pc2    <= '0;
      bus.out_nop1   <= 1'b0;
      bus.out_nop2   <= 1'b0;
    end else if (load) begin
      bus.out_valid  <= 1'b1;
      bus.out_instr1 <= beat_instr1;
      bus.out_instr2 <= beat_instr2;
      bus.out_pc1    <= beat_pc1;
      bus.out_pc2    <= beat_pc2;
      bus.out_nop1   <= beat_nop1;
      bus.out_nop2   <= beat_nop2;
    end else if (bus.issue_ready) begin
      bus.out_valid  <= 1'b0;
      bus.out_nop1   <= 1'b0;
      bus.out_nop2   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dual_issue_split_issuer.sv
// Directed scenarios plus a randomized run against a queue-based model of the
// pair buffer, split sequencing and output stage.
module tb_dual_issue_split_issuer;

  localparam int          XLEN  = 32;
  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] ADDI1 = 32'h0010_0093;
  localparam logic [31:0] ADDI2 = 32'h0020_0113;
  localparam logic [31:0] ADD3  = 32'h0010_81B3;

  typedef struct {
    logic [31:0] i1;
    logic [31:0] i2;
    logic [31:0] pc;
    bit          split;
  } pair_t;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   n_vec = 0;
  int   n_err = 0;

  dual_issue_split_issuer_if #(.XLEN(XLEN)) bus ();

  dual_issue_split_issuer #(
    .XLEN(XLEN), .DEPTH(DEPTH), .NOP_INSTR(NOP)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus)
  );

  always #5 clk = ~clk;

  logic [130:0] obs;
  assign obs = {bus.out_valid, bus.out_instr1, bus.out_instr2, bus.out_pc1,
                bus.out_pc2, bus.out_nop1, bus.out_nop2};

  function automatic logic [130:0] beat(logic v, logic [31:0] i1, logic [31:0] i2,
                                        logic [31:0] p1, logic [31:0] p2, logic n1, logic n2);
    return {v, i1, i2, p1, p2, n1, n2};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(logic [31:0] i1, logic [31:0] i2, logic [31:0] pc);
    bus.in_valid  = 1'b1;
    bus.in_instr1 = i1;
    bus.in_instr2 = i2;
    bus.in_pc     = pc;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; bus.in_valid = 1'b0; bus.split_req = 1'b0;
    bus.issue_ready = 1'b1; bus.in_instr1 = '0; bus.in_instr2 = '0; bus.in_pc = '0;
    step(); step();
    n_vec++;
    if (bus.in_ready !== 1'b0) begin
      n_err++; $display("[TB] FAIL reset_in_ready got=%b want=0", bus.in_ready);
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if (obs !== beat(1'b0, NOP, NOP, 32'h0, 32'h0, 1'b0, 1'b0)) begin
      n_err++; $display("[TB] FAIL reset_outputs got=%h want=%h", obs,
                        beat(1'b0, NOP, NOP, 32'h0, 32'h0, 1'b0, 1'b0));
    end
    n_vec++;
    if ({bus.in_ready, bus.head_instr1, bus.head_instr2} !== {1'b1, NOP, NOP}) begin
      n_err++; $display("[TB] FAIL reset_head got=%b/%h/%h want=1/%h/%h",
                        bus.in_ready, bus.head_instr1, bus.head_instr2, NOP, NOP);
    end
  endtask

  task automatic test_single_pair();
    offer(ADDI1, ADDI2, 32'h100);
    step();
    bus.in_valid = 1'b0;
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.head_instr1 !== ADDI1) begin
      n_err++; $display("[TB] FAIL single_latency got valid=%b head=%h want valid=0 head=%h",
                        bus.out_valid, bus.head_instr1, ADDI1);
    end
    step();
    n_vec++;
    if (obs !== beat(1'b1, ADDI1, ADDI2, 32'h100, 32'h104, 1'b0, 1'b0)) begin
      n_err++; $display("[TB] FAIL single_beat got=%h want=%h", obs,
                        beat(1'b1, ADDI1, ADDI2, 32'h100, 32'h104, 1'b0, 1'b0));
    end
    step();
    n_vec++;
    if ({bus.out_valid, bus.out_nop1, bus.out_nop2} !== 3'b000) begin
      n_err++; $display("[TB] FAIL single_drain got=%b want=000",
                        {bus.out_valid, bus.out_nop1, bus.out_nop2});
    end
  endtask

  task automatic test_split();
    offer(ADDI1, ADD3, 32'h200);
    step();
    offer(ADDI2, ADDI1, 32'h300);
    bus.split_req = 1'b1;
    step();
    bus.in_valid = 1'b0;
    n_vec++;
    if (obs !== beat(1'b1, ADDI1, NOP, 32'h200, 32'h204, 1'b0, 1'b1)) begin
      n_err++; $display("[TB] FAIL split_beat1 got=%h want=%h", obs,
                        beat(1'b1, ADDI1, NOP, 32'h200, 32'h204, 1'b0, 1'b1));
    end
    step();
    bus.split_req   = 1'b0;
    bus.issue_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      n_vec++;
      if (obs !== beat(1'b1, NOP, ADD3, 32'h200, 32'h204, 1'b1, 1'b0)) begin
        n_err++; $display("[TB] FAIL split_beat2_hold%0d got=%h want=%h", c, obs,
                          beat(1'b1, NOP, ADD3, 32'h200, 32'h204, 1'b1, 1'b0));
      end
      n_vec++;
      if (bus.head_instr1 !== ADDI2 || bus.in_ready !== 1'b1) begin
        n_err++; $display("[TB] FAIL split_head_hold%0d got=%h/%b want=%h/1", c,
                          bus.head_instr1, bus.in_ready, ADDI2);
      end
      if (c < 3) step();
    end
    bus.issue_ready = 1'b1;
    step();
    n_vec++;
    if (obs !== beat(1'b1, ADDI2, ADDI1, 32'h300, 32'h304, 1'b0, 1'b0)) begin
      n_err++; $display("[TB] FAIL split_next_pair got=%h want=%h", obs,
                        beat(1'b1, ADDI2, ADDI1, 32'h300, 32'h304, 1'b0, 1'b0));
    end
    step();
    n_vec++;
    if (bus.out_valid !== 1'b0) begin
      n_err++; $display("[TB] FAIL split_drain got=%b want=0", bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int          accepted = 0;
    int          ng = 0;
    logic [31:0] got [8];
    bit          acc;
    bus.issue_ready = 1'b0;
    bus.split_req   = 1'b0;
    for (int k = 0; k < 4; k++) begin
      offer(32'h1000_0000 + k, 32'h2000_0000 + k, 32'h1000 + 32'h10 * k);
      #1;
      if (bus.in_ready === 1'b1) accepted++;
      if (k < 3) step();
    end
    n_vec++;
    if (accepted != 3 || bus.in_ready !== 1'b0) begin
      n_err++; $display("[TB] FAIL b2b_fill got accepted=%0d ready=%b want 3/0",
                        accepted, bus.in_ready);
    end
    bus.issue_ready = 1'b1;
    #1;
    n_vec++;
    if (bus.in_ready !== 1'b0) begin
      n_err++; $display("[TB] FAIL b2b_full_pop_ready got=%b want=0", bus.in_ready);
    end
    for (int c = 0; c < 12; c++) begin
      if (bus.out_valid === 1'b1 && ng < 8) begin
        got[ng] = bus.out_pc1;
        ng++;
      end
      acc = bus.in_valid && bus.in_ready;
      step();
      if (acc) bus.in_valid = 1'b0;
    end
    n_vec++;
    if (ng != 4) begin
      n_err++; $display("[TB] FAIL b2b_count got=%0d want=4", ng);
    end
    for (int k = 0; k < 4 && k < ng; k++) begin
      n_vec++;
      if (got[k] !== 32'h1000 + 32'h10 * k) begin
        n_err++; $display("[TB] FAIL b2b_order%0d got=%h want=%h", k, got[k],
                          32'h1000 + 32'h10 * k);
      end
    end
  endtask

  task automatic test_flush();
    bus.issue_ready = 1'b1;
    offer(ADDI1, ADD3, 32'h3000);
    step();
    bus.in_valid  = 1'b0;
    bus.split_req = 1'b1;
    step();
    bus.split_req = 1'b0;
    flush = 1'b1;
    offer(32'hDEAD_0001, 32'hDEAD_0002, 32'h4000);
    step();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    n_vec++;
    if (obs !== beat(1'b0, NOP, NOP, 32'h0, 32'h0, 1'b0, 1'b0)) begin
      n_err++; $display("[TB] FAIL flush_outputs got=%h want=%h", obs,
                        beat(1'b0, NOP, NOP, 32'h0, 32'h0, 1'b0, 1'b0));
    end
    n_vec++;
    if (bus.head_instr1 !== NOP || bus.in_ready !== 1'b1) begin
      n_err++; $display("[TB] FAIL flush_empty got head=%h ready=%b want %h/1",
                        bus.head_instr1, bus.in_ready, NOP);
    end
    offer(ADDI2, ADDI1, 32'h5000);
    step();
    bus.in_valid = 1'b0;
    step();
    n_vec++;
    if (obs !== beat(1'b1, ADDI2, ADDI1, 32'h5000, 32'h5004, 1'b0, 1'b0)) begin
      n_err++; $display("[TB] FAIL flush_fresh_pair got=%h want=%h", obs,
                        beat(1'b1, ADDI2, ADDI1, 32'h5000, 32'h5004, 1'b0, 1'b0));
    end
    step();
    n_vec++;
    if (bus.out_valid !== 1'b0) begin
      n_err++; $display("[TB] FAIL flush_dropped_pair got=%b want=0", bus.out_valid);
    end
  endtask

  task automatic test_reset_midstream();
    bus.issue_ready = 1'b0;
    offer(ADDI1, ADDI2, 32'h600);
    step();
    offer(ADD3, ADDI1, 32'h700);
    step();
    rst = 1'b1;
    #1;
    n_vec++;
    if (bus.in_ready !== 1'b0) begin
      n_err++; $display("[TB] FAIL rst_mid_ready got=%b want=0", bus.in_ready);
    end
    step();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    n_vec++;
    if (obs !== beat(1'b0, NOP, NOP, 32'h0, 32'h0, 1'b0, 1'b0)) begin
      n_err++; $display("[TB] FAIL rst_mid_outputs got=%h want=%h", obs,
                        beat(1'b0, NOP, NOP, 32'h0, 32'h0, 1'b0, 1'b0));
    end
    n_vec++;
    if (bus.in_ready !== 1'b1 || bus.head_instr1 !== NOP) begin
      n_err++; $display("[TB] FAIL rst_mid_after got ready=%b head=%h want 1/%h",
                        bus.in_ready, bus.head_instr1, NOP);
    end
    bus.issue_ready = 1'b1;
  endtask

  task automatic test_pc_wrap();
    offer(ADDI1, ADDI2, 32'hFFFF_FFFC);
    step();
    bus.in_valid = 1'b0;
    step();
    n_vec++;
    if (obs !== beat(1'b1, ADDI1, ADDI2, 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b0)) begin
      n_err++; $display("[TB] FAIL pc_wrap got=%h want=%h", obs,
                        beat(1'b1, ADDI1, ADDI2, 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b0));
    end
    step();
  endtask

  task automatic test_random();
    pair_t       mq[$];
    pair_t       p;
    pair_t       h;
    bit          half_done = 0;
    bit          mv = 0, mn1 = 0, mn2 = 0, exp_rdy, ld;
    logic [31:0] mi1 = NOP, mi2 = NOP, mp1 = 0, mp2 = 0;
    rst = 1'b1; flush = 1'b0; bus.in_valid = 1'b0;
    step();
    for (int c = 0; c < 1500; c++) begin
      rst   = ($urandom_range(0, 199) == 0);
      flush = !rst && ($urandom_range(0, 39) == 0);
      p.i1 = $urandom; p.i2 = $urandom;
      p.pc = $urandom & 32'hFFFF_FFFC;
      p.split = ($urandom_range(0, 2) == 0);
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_instr1 = p.i1; bus.in_instr2 = p.i2; bus.in_pc = p.pc;
      bus.issue_ready = ($urandom_range(0, 3) != 0);
      bus.split_req   = (mq.size() != 0) ? mq[0].split : 1'($urandom_range(0, 1));
      #1;
      exp_rdy = !rst && (mq.size() != DEPTH);
      n_vec++;
      if (bus.in_ready !== exp_rdy) begin
        n_err++; $display("[TB] FAIL rand_in_ready cyc=%0d got=%b want=%b", c, bus.in_ready, exp_rdy);
      end
      n_vec++;
      if (mq.size() != 0 ? {bus.head_instr1, bus.head_instr2} !== {mq[0].i1, mq[0].i2}
                         : {bus.head_instr1, bus.head_instr2} !== {NOP, NOP}) begin
        n_err++; $display("[TB] FAIL rand_head cyc=%0d got=%h/%h", c, bus.head_instr1, bus.head_instr2);
      end
      if (rst || flush) begin
        mq.delete(); half_done = 0; mv = 0; mn1 = 0; mn2 = 0;
        mi1 = NOP; mi2 = NOP; mp1 = 0; mp2 = 0;
      end else begin
        ld = (mq.size() != 0) && (!mv || bus.issue_ready);
        if (ld) begin
          h = mq[0]; mv = 1; mp1 = h.pc; mp2 = h.pc + 32'd4;
          if (half_done) begin
            mi1 = NOP; mi2 = h.i2; mn1 = 1; mn2 = 0; half_done = 0;
            void'(mq.pop_front());
          end else if (h.split) begin
            mi1 = h.i1; mi2 = NOP; mn1 = 0; mn2 = 1; half_done = 1;
          end else begin
            mi1 = h.i1; mi2 = h.i2; mn1 = 0; mn2 = 0;
            void'(mq.pop_front());
          end
        end else if (bus.issue_ready) begin
          mv = 0; mn1 = 0; mn2 = 0;
        end
        if (bus.in_valid && exp_rdy) mq.push_back(p);
      end
      step();
      n_vec++;
      if ({bus.out_valid, bus.out_nop1, bus.out_nop2} !== {mv, mn1, mn2}) begin
        n_err++; $display("[TB] FAIL rand_flags cyc=%0d got=%b want=%b", c,
                          {bus.out_valid, bus.out_nop1, bus.out_nop2}, {mv, mn1, mn2});
      end
      if (mv || rst || flush) begin
        n_vec++;
        if (obs !== beat(mv, mi1, mi2, mp1, mp2, mn1, mn2)) begin
          n_err++; $display("[TB] FAIL rand_beat cyc=%0d got=%h want=%h", c, obs,
                            beat(mv, mi1, mi2, mp1, mp2, mn1, mn2));
        end
      end
    end
    rst = 1'b0; flush = 1'b0; bus.in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_pair();
    test_split();
    test_back_to_back();
    test_flush();
    test_reset_midstream();
    test_pc_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
